// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI bit-stuffing line codec.
// Used by the encoder now and by a future stuff-stripping decoder.
package nrzi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } nrzi_state_t;

    localparam logic LINE_HIGH   = 1'b1;
    localparam logic LINE_LOW    = 1'b0;
    localparam int   RUN_LEN_MAX = 15;

    // Run counter width: enough to hold run_len itself, never narrower than one bit
    function automatic int cnt_width(input int run_len);
        return (run_len < 1) ? 1 : $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/nrzi_run_counter.sv
// Counts consecutive hold bits and flags the increment that lands on LIMIT.
// LIMIT = 0 disables counting, so at_limit never fires.
module nrzi_run_counter
    import nrzi_pkg::*;
#(
    parameter int LIMIT = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic at_limit
);

    localparam int             W       = cnt_width(LIMIT);
    localparam logic [W-1:0]   LIMIT_W = W'(LIMIT);
    localparam logic [W-1:0]   LAST_W  = (LIMIT == 0) ? W'(1'b0) : W'(LIMIT - 1);

    logic [W-1:0] count_r;

    // Run length register: clear has priority, count saturates at LIMIT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= W'(1'b0);
        end else if (clear) begin
            count_r <= W'(1'b0);
        end else if (incr && (count_r < LIMIT_W)) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_limit = (LIMIT > 0) & incr & (count_r == LAST_W);

endmodule

// File: rtl/nrzi_stuff_encoder.sv
// NRZI line encoder with bit stuffing: one bit per handshake, one-cycle latency,
// a forced transition after RUN_LEN consecutive hold bits.
module nrzi_stuff_encoder
    import nrzi_pkg::*;
#(
    parameter int   RUN_LEN    = 6,
    parameter logic TOGGLE_ON  = 1'b0,
    parameter logic IDLE_LEVEL = LINE_HIGH
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_clear,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic z,
    output logic out_active,
    output logic out_stuff
);

    localparam int RUN_EFF = (RUN_LEN > RUN_LEN_MAX) ? RUN_LEN_MAX : RUN_LEN;

    nrzi_state_t state_r, state_nx_s;
    logic        z_r, z_nx_s;
    logic        active_r, active_nx_s;
    logic        stuff_r, stuff_nx_s;
    logic        last_pend_r, last_pend_nx_s;
    logic        accept_s, hold_s, trigger_s;
    logic        cnt_clear_s, cnt_incr_s;

    assign in_ready   = ~sync_clear & (state_r != STUFF);
    assign accept_s   = in_valid & in_ready;
    assign hold_s     = (in_bit != TOGGLE_ON);
    assign cnt_incr_s = accept_s & hold_s;

    nrzi_run_counter #(
        .LIMIT (RUN_EFF)
    ) u_run_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .incr     (cnt_incr_s),
        .at_limit (trigger_s)
    );

    // Next-state, next line level and run-counter clear
    always_comb begin
        state_nx_s     = state_r;
        z_nx_s         = z_r;
        active_nx_s    = 1'b0;
        stuff_nx_s     = 1'b0;
        last_pend_nx_s = last_pend_r;
        cnt_clear_s    = 1'b0;
        if (sync_clear) begin
            state_nx_s     = IDLE;
            z_nx_s         = IDLE_LEVEL;
            last_pend_nx_s = 1'b0;
            cnt_clear_s    = 1'b1;
        end else if (state_r == STUFF) begin
            z_nx_s         = ~z_r;
            active_nx_s    = 1'b1;
            stuff_nx_s     = 1'b1;
            last_pend_nx_s = 1'b0;
            cnt_clear_s    = 1'b1;
            state_nx_s     = last_pend_r ? IDLE : DATA;
        end else if (accept_s) begin
            active_nx_s = 1'b1;
            if (hold_s) begin
                z_nx_s = z_r;
            end else begin
                z_nx_s      = ~z_r;
                cnt_clear_s = 1'b1;
            end
            // A triggering last bit still gets its stuff bit before returning to IDLE
            if (trigger_s) begin
                state_nx_s     = STUFF;
                last_pend_nx_s = in_last;
            end else if (in_last) begin
                state_nx_s  = IDLE;
                cnt_clear_s = 1'b1;
            end else begin
                state_nx_s = DATA;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // State and registered line outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            z_r         <= IDLE_LEVEL;
            active_r    <= 1'b0;
            stuff_r     <= 1'b0;
            last_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            z_r         <= z_nx_s;
            active_r    <= active_nx_s;
            stuff_r     <= stuff_nx_s;
            last_pend_r <= last_pend_nx_s;
        end
    end

    assign z          = z_r;
    assign out_active = active_r;
    assign out_stuff  = stuff_r;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// Directed, table-driven bench for nrzi_stuff_encoder: default build plus
// a stuffing-disabled build and an inverted-polarity build on shared stimulus.
module tb_nrzi_stuff_encoder;

    typedef struct {
        int    dut;
        logic  v, b, l, c;
        logic  rdy, z, act, stf;
        string tag;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, sync_clear, in_valid, in_bit, in_last;
    logic rdy_a, z_a, act_a, stf_a;
    logic rdy_b, z_b, act_b, stf_b;
    logic rdy_c, z_c, act_c, stf_c;
    logic [2:0] rdy_w, z_w, act_w, stf_w;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t tbl[$];

    assign rdy_w = {rdy_c, rdy_b, rdy_a};
    assign z_w   = {z_c, z_b, z_a};
    assign act_w = {act_c, act_b, act_a};
    assign stf_w = {stf_c, stf_b, stf_a};

    nrzi_stuff_encoder u_dut_a (
        .clock(clock), .reset(reset), .sync_clear(sync_clear),
        .in_valid(in_valid), .in_ready(rdy_a), .in_bit(in_bit), .in_last(in_last),
        .z(z_a), .out_active(act_a), .out_stuff(stf_a)
    );

    nrzi_stuff_encoder #(.RUN_LEN(0)) u_dut_b (
        .clock(clock), .reset(reset), .sync_clear(sync_clear),
        .in_valid(in_valid), .in_ready(rdy_b), .in_bit(in_bit), .in_last(in_last),
        .z(z_b), .out_active(act_b), .out_stuff(stf_b)
    );

    nrzi_stuff_encoder #(.RUN_LEN(3), .TOGGLE_ON(1'b1), .IDLE_LEVEL(1'b0)) u_dut_c (
        .clock(clock), .reset(reset), .sync_clear(sync_clear),
        .in_valid(in_valid), .in_ready(rdy_c), .in_bit(in_bit), .in_last(in_last),
        .z(z_c), .out_active(act_c), .out_stuff(stf_c)
    );

    task automatic chk(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic v, input logic b, input logic l,
                                input logic c, input logic rdy, input logic z, input logic act,
                                input logic stf, input string tag);
        vec_t t;
        t.dut = d; t.v = v; t.b = b; t.l = l; t.c = c;
        t.rdy = rdy; t.z = z; t.act = act; t.stf = stf; t.tag = tag;
        return t;
    endfunction

    // Drive at negedge, check in_ready before the edge and registered outputs after it
    task automatic apply(input vec_t t, input int idx);
        @(negedge clock);
        in_valid   = t.v;
        in_bit     = t.b;
        in_last    = t.l;
        sync_clear = t.c;
        #1;
        chk($sformatf("%s#%0d.in_ready", t.tag, idx), rdy_w[t.dut], t.rdy);
        @(posedge clock);
        #1;
        chk($sformatf("%s#%0d.z", t.tag, idx), z_w[t.dut], t.z);
        chk($sformatf("%s#%0d.out_active", t.tag, idx), act_w[t.dut], t.act);
        chk($sformatf("%s#%0d.out_stuff", t.tag, idx), stf_w[t.dut], t.stf);
    endtask

    initial begin
        reset      = 1'b1;
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        in_last    = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset.z", z_a, 1'b1);
        chk("reset.in_ready", rdy_a, 1'b1);
        chk("reset.out_active", act_a, 1'b0);
        chk("reset.out_stuff", stf_a, 1'b0);
        chk("reset.z_c", z_c, 1'b0);
        reset = 1'b0;

        // Mid-packet asynchronous reset
        apply(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "pre_rst"), 0);
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst.z", z_a, 1'b1);
        chk("async_rst.in_ready", rdy_a, 1'b1);
        chk("async_rst.out_active", act_a, 1'b0);
        chk("async_rst.out_stuff", stf_a, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "idle"), i);
        end

        // Basic encode 0,1,1,0 from z=1
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "basic"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "basic"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "basic"));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "basic"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "basic"));
        // Seven 1s: stuff after the sixth, seventh accepted after the bubble
        repeat (6) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "seven"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "seven"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "seven"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "seven"));
        // in_last on the sixth 1 still gets its stuff bit
        repeat (5) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "laststuff"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "laststuff"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "laststuff"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "laststuff"));
        // Next packet needs six fresh 1s
        repeat (6) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "nextpkt"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "nextpkt"));
        // sync_clear during STUFF discards the stuff bit and the run
        repeat (6) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "sclr"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sclr"));
        // Run count restarts from 0 and survives an in_valid gap
        repeat (2) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "gap"));
        tbl.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "gap"));
        repeat (3) tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "gap"));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "gap"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "gap"));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap"));
        // RUN_LEN = 0: twenty 1s, no stuffing, line constant
        tbl.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "nostuff"));
        repeat (20) tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "nostuff"));
        tbl.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "nostuff"));
        // TOGGLE_ON = 1, IDLE_LEVEL = 0, RUN_LEN = 3: bits 1,0,0,0 then stuff
        tbl.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "inv"));
        tbl.push_back(mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "inv"));
        repeat (2) tbl.push_back(mk(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "inv"));
        tbl.push_back(mk(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "inv"));
        tbl.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "inv"));
        tbl.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "inv"));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
